// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and line levels for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_shift.sv
// rtl/uart_tx_shift.sv - LSB-first data shift register for the UART transmitter
// Also latches the even parity of the accepted word when UART_TX_PARITY_EN is defined.
module uart_tx_shift
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_bit
`ifdef UART_TX_PARITY_EN
  ,
  output logic                 o_parity
`endif
);

  logic [DATA_BITS-1:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign o_bit = r_shift[0];

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the word as accepted, not from the shifting copy.
  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity <= 1'b0;
    end else if (i_load) begin
      r_parity <= ^i_data;
    end
  end

  assign o_parity = r_parity;
`endif

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit FSM: accept handshake, baud enable, frame sequencing
// Even parity bit is added when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_stick,
  output logic                 o_baud_en,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e     r_state;
  tx_state_e     w_next;
  logic [CW-1:0] r_bit_cnt;
  logic          r_stop_cnt;
  logic          r_done;
  logic          w_accept;
  logic          w_shift;
  logic          w_last_stop;
  logic          w_bit;
`ifdef UART_TX_PARITY_EN
  logic          w_parity;
`endif

  assign w_accept    = (r_state == IDLE) && i_valid;
  assign w_shift     = (r_state == DATA) && i_stick;
  assign w_last_stop = (r_state == STOP) && i_stick && (r_stop_cnt == LAST_STOP);

  uart_tx_shift #(
    .DATA_BITS(DATA_BITS)
  ) u_shift (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (i_data),
    .o_bit   (w_bit)
`ifdef UART_TX_PARITY_EN
    ,
    .o_parity(w_parity)
`endif
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ticks are ignored in IDLE, so a tick coinciding with accept is dropped.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (i_valid) w_next = START;
      START: if (i_stick) w_next = DATA;
      DATA: begin
        if (i_stick && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (i_stick) w_next = STOP;
`endif
      STOP:  if (w_last_stop) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last_stop;
      if (w_accept) begin
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
      end else begin
        if (w_shift) r_bit_cnt <= r_bit_cnt + CW'(1);
        if ((r_state == STOP) && i_stick) r_stop_cnt <= ~r_stop_cnt;
      end
    end
  end

  always_comb begin
    o_ready   = 1'b0;
    o_baud_en = 1'b1;
    o_busy    = 1'b1;
    o_tx      = UART_IDLE_LEVEL;
    case (r_state)
      IDLE: begin
        o_ready   = 1'b1;
        o_baud_en = 1'b0;
        o_busy    = 1'b0;
      end
      START:  o_tx = UART_START_LEVEL;
      DATA:   o_tx = w_bit;
`ifdef UART_TX_PARITY_EN
      PARITY: o_tx = w_parity;
`endif
      default: o_tx = UART_IDLE_LEVEL;
    endcase
  end

  assign o_done = r_done;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sequences the baud generator and serializes one data word per frame onto the serial line. It accepts words over a valid/ready handshake, enables the baud generator only while a frame is in flight, and advances one bit per baud tick. The block sits between the host-side byte source and the `baud_generator`, whose `o_stick` drives this block's `i_stick` and whose enable is driven by `o_baud_en`.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5–9.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `i_clk` input 1: system clock, the same clock that drives `baud_generator`.
- `i_rst` input 1: reset, synchronous to `i_clk`, active-high.
- `i_data` input `DATA_BITS`: word to transmit. Sampled on the accept cycle.
- `i_valid` input 1: `i_data` is valid.
- `o_ready` output 1: controller can accept a word.
- `i_stick` input 1: baud tick, a one-cycle pulse once per bit period.
- `o_baud_en` output 1: enable to the baud generator. While low, the generator's counter is held cleared.
- `o_tx` output 1: serial line, idle high.
- `o_busy` output 1: a frame is in progress.
- `o_done` output 1: one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY (only when the parity macro is defined), STOP.
- IDLE:
  - `o_ready=1`, `o_tx=1`, `o_baud_en=0`, `o_busy=0`.
  - `i_stick` is ignored.
  - Accept occurs when `i_valid && o_ready` on a rising edge. On accept, latch `i_data` into the shift register, clear the bit counter, and go to START.
- START: `o_tx=0`. On `i_stick`, go to DATA.
- DATA:
  - `o_tx` = shift register bit 0, so data goes out LSB first.
  - On each `i_stick`, shift right by one and increment the bit counter.
  - When the counter reaches `DATA_BITS-1` and `i_stick` arrives, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: `o_tx` = parity bit. On `i_stick`, go to STOP.
- STOP:
  - `o_tx=1`.
  - Count `STOP_BITS` ticks, then return to IDLE and pulse `o_done`.
- `o_baud_en=1` and `o_busy=1` in every state except IDLE.
- `o_ready=0` whenever the state is not IDLE. `i_valid` and `i_data` are ignored outside IDLE.
- Bit counter width is `$clog2(DATA_BITS)`. The stop counter is 1 bit.

## Timing
- Reset values, all taking effect at the first edge with `i_rst=1`: state IDLE, `o_tx=1`, `o_ready=1`, `o_baud_en=0`, `o_busy=0`, `o_done=0`, counters 0, shift register 0.
- Reset mid-frame: the line returns to 1 at that edge. The frame is abandoned and there is no `o_done`.
- Accept at edge N: `o_tx=0`, `o_baud_en=1` and `o_ready=0` from edge N onward, registered.
- Because the generator restarts from zero when enabled, the start bit lasts exactly one baud period.
- Every transition on `i_stick` is registered: line bit k changes at the edge where `i_stick`=1 is sampled.
- `o_done` is high for the single cycle after the last stop tick edge. In that same cycle `o_ready=1`.
- Back-to-back frames: if `i_valid=1` during the `o_done` cycle, that word is accepted in the same cycle. The minimum idle gap between frames is therefore 1 clock.
- An `i_stick` that coincides with the accept edge is ignored. It cannot occur when the generator is disabled, but it must be tolerated.
- Frame length in ticks = 1 + `DATA_BITS` + parity + `STOP_BITS`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - The parity bit is even parity, `^data`, computed from the word latched at accept.
  - Frames are one tick longer.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic. DATA goes directly to STOP.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_e`, a 3-bit enum of IDLE/START/DATA/PARITY/STOP.
  - Constants `UART_IDLE_LEVEL=1'b1` and `UART_START_LEVEL=1'b0`.
- One sub-module, `uart_tx_shift`, holds the shift register:
  - Inputs: load, shift, and data in.
  - Output: bit 0.
  - Also computes parity when `UART_TX_PARITY_EN` is defined.
- FSM and counters live in `uart_tx_ctrl`.

## Test plan
- **Reset:** hold `i_rst=1` for 3 cycles with `i_valid=1` → `o_tx=1`, `o_ready=1`, `o_baud_en=0`, no accept.
- **Single frame:** `DATA_BITS=8`, `STOP_BITS=1`, generator with `BAUDRATE_VALUE=21`, send `8'hA5`.
  - Line: 0, then bits 1,0,1,0,0,1,0,1, then 1.
  - Each bit is 21 clocks long.
  - `o_done` pulses 210 cycles after accept.
- **Back-to-back:** assert `i_valid` continuously with `8'h00`, then `8'hFF` → second start bit begins 1 clock after the first `o_done`. No idle bit period between frames.
- **Parity:** with `UART_TX_PARITY_EN`, send `8'h07` → parity bit 1, frame of 11 ticks. Send `8'h03` → parity bit 0.
- **Mid-frame reset:** assert `i_rst` during DATA bit 3 → `o_tx=1` and `o_baud_en=0` on the next edge. No `o_done`. The next word transmits correctly.
- **Two stop bits:** `STOP_BITS=2`, send `8'h55` → line high for 2 tick periods before `o_done`. `o_ready` stays low throughout the frame.
